// File: rtl/poly_mau_seq_pkg.sv
// Shared definitions for the polynomial MAU operand/result sequencer.
// Contents: default widths and limits, FSM state encoding, the latched MAU
// mode-control bundle and a small state helper.
package poly_mau_seq_pkg;

  localparam int unsigned DefDataW      = 24;
  localparam int unsigned DefAddrW      = 8;
  localparam int unsigned DefInflW      = 5;
  localparam int unsigned DefTimeoutCyc = 64;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StDrain = 3'd2,
    StDone  = 3'd3,
    StFlush = 3'd4
  } seq_state_e;

  // MAU mode controls, latched once per job.
  typedef struct packed {
    logic [3:0] alu_mode;
    logic       kd_sel;
    logic [1:0] decompose;
    logic [1:0] compress;
    logic [1:0] duv_mode;
  } mau_cfg_t;

  function automatic logic state_busy(seq_state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/poly_mau_seq_addr_gen.sv
// Base + offset address counter with wrap-around and a terminal flag.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   clear     restart the offset at zero (job start)
//   step      advance the offset by one
//   base      start address (already latched by the caller)
//   len       number of addresses in the job, 0..2^ADDR_W
//   addr      base + offset, wrapping modulo 2^ADDR_W
//   term      offset has reached len
module poly_mau_seq_addr_gen
  import poly_mau_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr,
  output logic              term
);

  // One bit wider than the address so a full 2^ADDR_W job can terminate.
  logic [ADDR_W:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign addr = base + count_q[ADDR_W-1:0];
  assign term = (count_q == len);

endmodule

// File: rtl/poly_mau_seq.sv
// Operand-issue / result-collect sequencer for the polynomial MAU.
// Reads cfg_len operand tuples (a,b,c,d) from four banks, streams them into the
// MAU one per cycle, captures {o1,o0} on each mau_valid and writes them to the
// result bank. MAU mode controls are latched at job start and held until the
// next start.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        job start pulse (idle only), job abandon
//   cfg_*               job length, read/write base, MAU mode controls
//   rd_en, rd_addr      operand bank read (data returns one cycle later)
//   rd_data_a..d        operand words
//   mau_enable, mau_a..d, mau_<mode>   MAU issue side
//   mau_valid, mau_o0/1                MAU result side
//   wr_en, wr_addr, wr_data0/1         result bank write
//   busy, done, err_unexp              status (err_unexp sticky until start)
// Build option: POLY_SEQ_TIMEOUT_EN adds a DRAIN/FLUSH watchdog and the
// err_timeout output.
module poly_mau_seq
  import poly_mau_seq_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned INFL_W      = DefInflW
`ifdef POLY_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [ADDR_W-1:0] cfg_rd_base,
  input  logic [ADDR_W-1:0] cfg_wr_base,
  input  logic [3:0]        cfg_alu_mode,
  input  logic              cfg_kd_sel,
  input  logic [1:0]        cfg_decompose,
  input  logic [1:0]        cfg_compress,
  input  logic [1:0]        cfg_duv_mode,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  input  logic [DATA_W-1:0] rd_data_c,
  input  logic [DATA_W-1:0] rd_data_d,
  output logic              mau_enable,
  output logic [DATA_W-1:0] mau_a,
  output logic [DATA_W-1:0] mau_b,
  output logic [DATA_W-1:0] mau_c,
  output logic [DATA_W-1:0] mau_d,
  output logic [3:0]        mau_alu_mode,
  output logic              mau_kd_sel,
  output logic [1:0]        mau_decompose,
  output logic [1:0]        mau_compress,
  output logic [1:0]        mau_duv_mode,
  input  logic              mau_valid,
  input  logic [DATA_W-1:0] mau_o0,
  input  logic [DATA_W-1:0] mau_o1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data0,
  output logic [DATA_W-1:0] wr_data1,
  output logic              busy,
  output logic              done,
  output logic              err_unexp
`ifdef POLY_SEQ_TIMEOUT_EN
  ,
  output logic              err_timeout
`endif
);

  seq_state_e        state_q, state_d;
  mau_cfg_t          cfg_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W-1:0] rd_base_q, wr_base_q;
  logic [INFL_W-1:0] infl_q, infl_d;
  logic              mau_enable_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data0_q, wr_data1_q;
  logic              err_unexp_q;

  logic              start_acc;
  logic              valid_ok;
  logic              accept;
  logic              rd_term, wr_term;
  logic [ADDR_W-1:0] rd_addr_gen, wr_addr_gen;
  logic              timeout_hit;

  // abort wins over a simultaneous start.
  assign start_acc = (state_q == StIdle) && start && !abort;
  // A valid only counts when something is actually outstanding.
  assign valid_ok  = mau_valid && (infl_q != '0);
  assign accept    = valid_ok && !abort && ((state_q == StIssue) || (state_q == StDrain));

  // Zero-length jobs pass through ISSUE for one cycle without reading.
  assign rd_en = (state_q == StIssue) && !rd_term;

  poly_mau_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_rd_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (start_acc),
    .step  (rd_en),
    .base  (rd_base_q),
    .len   (len_q),
    .addr  (rd_addr_gen),
    .term  (rd_term)
  );

  poly_mau_seq_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_wr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (start_acc),
    .step  (accept),
    .base  (wr_base_q),
    .len   (len_q),
    .addr  (wr_addr_gen),
    .term  (wr_term)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_acc) state_d = StIssue;
      end
      StIssue: begin
        if (abort) begin
          state_d = StFlush;
        end else if (rd_term) begin
          state_d = (wr_term && (infl_q == '0)) ? StDone : StDrain;
        end
      end
      StDrain: begin
        if (abort) begin
          state_d = StFlush;
        end else if (wr_term && (infl_q == '0)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      StFlush: begin
        if (infl_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (timeout_hit) state_d = StIdle;
  end

  // Saturating up/down count of MAU ops issued but not yet returned.
  always_comb begin
    infl_d = infl_q;
    if (mau_enable_q && !valid_ok) begin
      if (infl_q != '1) infl_d = infl_q + {{(INFL_W-1){1'b0}}, 1'b1};
    end else if (!mau_enable_q && valid_ok) begin
      infl_d = infl_q - {{(INFL_W-1){1'b0}}, 1'b1};
    end
    // A watchdog exit abandons whatever the MAU still owes.
    if (timeout_hit) infl_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cfg_q        <= '0;
      len_q        <= '0;
      rd_base_q    <= '0;
      wr_base_q    <= '0;
      infl_q       <= '0;
      mau_enable_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data0_q   <= '0;
      wr_data1_q   <= '0;
      err_unexp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      infl_q       <= infl_d;
      // The read of the abort cycle is dropped rather than issued.
      mau_enable_q <= rd_en && !abort;
      wr_en_q      <= accept;
      if (accept) begin
        wr_addr_q  <= wr_addr_gen;
        wr_data0_q <= mau_o0;
        wr_data1_q <= mau_o1;
      end
      if (start_acc) begin
        cfg_q     <= '{alu_mode:  cfg_alu_mode,
                       kd_sel:    cfg_kd_sel,
                       decompose: cfg_decompose,
                       compress:  cfg_compress,
                       duv_mode:  cfg_duv_mode};
        len_q     <= cfg_len;
        rd_base_q <= cfg_rd_base;
        wr_base_q <= cfg_wr_base;
      end
      if (mau_valid && (infl_q == '0)) begin
        err_unexp_q <= 1'b1;
      end else if (start_acc) begin
        err_unexp_q <= 1'b0;
      end
    end
  end

`ifdef POLY_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            err_timeout_q;
  logic            waiting;

  assign waiting     = (state_q == StDrain) || (state_q == StFlush);
  assign timeout_hit = waiting && !mau_valid && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  // Counts consecutive DRAIN/FLUSH cycles without a MAU result.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (!waiting || mau_valid) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + {{(TmoW-1){1'b0}}, 1'b1};
      end
      if (timeout_hit) begin
        err_timeout_q <= 1'b1;
      end else if (start_acc) begin
        err_timeout_q <= 1'b0;
      end
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign timeout_hit = 1'b0;
`endif

  assign rd_addr       = rd_addr_gen;
  assign mau_enable    = mau_enable_q;
  // Bank output register supplies the operand stage; zero when not issuing.
  assign mau_a         = mau_enable_q ? rd_data_a : '0;
  assign mau_b         = mau_enable_q ? rd_data_b : '0;
  assign mau_c         = mau_enable_q ? rd_data_c : '0;
  assign mau_d         = mau_enable_q ? rd_data_d : '0;
  assign mau_alu_mode  = cfg_q.alu_mode;
  assign mau_kd_sel    = cfg_q.kd_sel;
  assign mau_decompose = cfg_q.decompose;
  assign mau_compress  = cfg_q.compress;
  assign mau_duv_mode  = cfg_q.duv_mode;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data0      = wr_data0_q;
  assign wr_data1      = wr_data1_q;
  assign busy          = state_busy(state_q);
  assign done          = (state_q == StDone);
  assign err_unexp     = err_unexp_q;

endmodule

// File: tb/tb_poly_mau_seq.sv
// Directed self-checking bench for poly_mau_seq with behavioural operand banks,
// a 3-cycle MAU model and a result bank.
module tb_poly_mau_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [8:0]  cfg_len;
  logic [7:0]  cfg_rd_base, cfg_wr_base;
  logic [3:0]  cfg_alu_mode;
  logic        cfg_kd_sel;
  logic [1:0]  cfg_decompose, cfg_compress, cfg_duv_mode;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic        mau_enable;
  logic [23:0] mau_a, mau_b, mau_c, mau_d;
  logic [3:0]  mau_alu_mode;
  logic        mau_kd_sel;
  logic [1:0]  mau_decompose, mau_compress, mau_duv_mode;
  logic        mau_valid;
  logic [23:0] mau_o0, mau_o1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data0, wr_data1;
  logic        busy, done, err_unexp;
`ifdef POLY_SEQ_TIMEOUT_EN
  logic        err_timeout;
`endif

  logic        inj_valid, suppress;
  int          checks, failures;

  always #5 clk = ~clk;

  poly_mau_seq u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .cfg_len       (cfg_len),
    .cfg_rd_base   (cfg_rd_base),
    .cfg_wr_base   (cfg_wr_base),
    .cfg_alu_mode  (cfg_alu_mode),
    .cfg_kd_sel    (cfg_kd_sel),
    .cfg_decompose (cfg_decompose),
    .cfg_compress  (cfg_compress),
    .cfg_duv_mode  (cfg_duv_mode),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .rd_data_c     (rd_data_c),
    .rd_data_d     (rd_data_d),
    .mau_enable    (mau_enable),
    .mau_a         (mau_a),
    .mau_b         (mau_b),
    .mau_c         (mau_c),
    .mau_d         (mau_d),
    .mau_alu_mode  (mau_alu_mode),
    .mau_kd_sel    (mau_kd_sel),
    .mau_decompose (mau_decompose),
    .mau_compress  (mau_compress),
    .mau_duv_mode  (mau_duv_mode),
    .mau_valid     (mau_valid),
    .mau_o0        (mau_o0),
    .mau_o1        (mau_o1),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data0      (wr_data0),
    .wr_data1      (wr_data1),
    .busy          (busy),
    .done          (done),
    .err_unexp     (err_unexp)
`ifdef POLY_SEQ_TIMEOUT_EN
    ,
    .err_timeout   (err_timeout)
`endif
  );

  // Operand banks, 1-cycle read latency.
  logic [23:0] bank_a [256];
  logic [23:0] bank_b [256];
  logic [23:0] bank_c [256];
  logic [23:0] bank_d [256];
  logic [47:0] res    [256];

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= bank_a[rd_addr];
      rd_data_b <= bank_b[rd_addr];
      rd_data_c <= bank_c[rd_addr];
      rd_data_d <= bank_d[rd_addr];
    end
  end

  // MAU model: o0 = a + 2b, o1 = c ^ rot12(d), latency 3.
  logic [2:0]  pv;
  logic [23:0] p0 [3];
  logic [23:0] p1 [3];

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[1:0], mau_enable & ~suppress};
      p0[0] <= mau_a + (mau_b << 1);
      p1[0] <= mau_c ^ {mau_d[11:0], mau_d[23:12]};
      p0[1] <= p0[0];
      p1[1] <= p1[0];
      p0[2] <= p0[1];
      p1[2] <= p1[1];
    end
  end

  assign mau_valid = pv[2] | inj_valid;
  assign mau_o0    = p0[2];
  assign mau_o1    = p1[2];

  always @(posedge clk) begin
    if (wr_en) res[wr_addr] <= {wr_data1, wr_data0};
  end

  function automatic logic [47:0] exp_res(input logic [7:0] idx);
    logic [23:0] o0, o1;
    o0 = bank_a[idx] + {bank_b[idx][22:0], 1'b0};
    o1 = bank_c[idx] ^ {bank_d[idx][11:0], bank_d[idx][23:12]};
    return {o1, o0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle traces, bit/index k = cycle k after the start edge.
  logic [31:0] tr_rd, tr_me, tr_wr, tr_dn, tr_bz;
  logic [23:0] tr_ma [32];
  logic [7:0]  tr_wa [32];
  logic [23:0] tr_wd [32];

  task automatic trace(input int k0, input int n);
    tr_rd = '0; tr_me = '0; tr_wr = '0; tr_dn = '0; tr_bz = '0;
    for (int k = k0; k < k0 + n; k++) begin
      tr_rd[5'(k)] = rd_en;
      tr_me[5'(k)] = mau_enable;
      tr_wr[5'(k)] = wr_en;
      tr_dn[5'(k)] = done;
      tr_bz[5'(k)] = busy;
      tr_ma[5'(k)] = mau_a;
      tr_wa[5'(k)] = wr_addr;
      tr_wd[5'(k)] = wr_data0;
      step();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  int rd_cnt, wr_cnt, done_cnt, drop_cyc;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; inj_valid = 1'b0; suppress = 1'b0;
    cfg_len = '0; cfg_rd_base = '0; cfg_wr_base = '0; cfg_alu_mode = '0;
    cfg_kd_sel = 1'b0; cfg_decompose = '0; cfg_compress = '0; cfg_duv_mode = '0;
    for (int i = 0; i < 256; i++) begin
      bank_a[i] = 24'(i * 7 + 3);
      bank_b[i] = 24'(i * 13 + 256);
      bank_c[i] = 24'(i * 65793);
      bank_d[i] = 24'(i * 40503 + 11);
    end
    repeat (3) step();

    // Reset state
    check("reset_ctrl", 64'({rd_en, mau_enable, wr_en, busy, done, err_unexp, rd_addr, wr_addr}),
          64'(0));
    check("reset_data", 64'({mau_a, wr_data0}), 64'(0));
    check("reset_cfg", 64'({mau_alu_mode, mau_kd_sel, mau_decompose, mau_compress, mau_duv_mode}),
          64'(0));
    rst = 1'b0;
    step();

    // 1: N=4, base 0 -> rd 1-4, enable 2-5, write 6-9, done 10
    cfg_len = 9'd4; cfg_rd_base = 8'h00; cfg_wr_base = 8'h10; cfg_alu_mode = 4'hA;
    cfg_kd_sel = 1'b1; cfg_decompose = 2'd2; cfg_compress = 2'd1; cfg_duv_mode = 2'd3;
    pulse_start();
    cfg_alu_mode = 4'h5; cfg_kd_sel = 1'b0; cfg_decompose = 2'd1; cfg_compress = 2'd2;
    cfg_duv_mode = 2'd0; cfg_len = 9'd7; cfg_wr_base = 8'h55;
    trace(1, 15);
    check("t1_rd_en", 64'(tr_rd), 64'h1E);
    check("t1_mau_enable", 64'(tr_me), 64'h3C);
    check("t1_wr_en", 64'(tr_wr), 64'h3C0);
    check("t1_done", 64'(tr_dn), 64'h400);
    check("t1_busy", 64'(tr_bz), 64'h7FE);
    check("t1_mau_a_first", 64'(tr_ma[2]), 64'(bank_a[0]));
    check("t1_mau_a_last", 64'(tr_ma[5]), 64'(bank_a[3]));
    check("t1_wr_addr_first", 64'(tr_wa[6]), 64'h10);
    check("t1_wr_addr_last", 64'(tr_wa[9]), 64'h13);
    check("t1_wr_data0", 64'(tr_wd[6]), 64'(exp_res(8'd0) & 48'hFF_FFFF));
    check("t1_cfg_held", 64'({mau_alu_mode, mau_kd_sel, mau_decompose, mau_compress, mau_duv_mode}),
          64'({4'hA, 1'b1, 2'd2, 2'd1, 2'd3}));
    for (int i = 0; i < 4; i++) begin
      check("t1_result", 64'(res[8'(16 + i)]), 64'(exp_res(8'(i))));
    end

    // 5: valid injected while idle
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    check("t5_err_set", 64'({err_unexp, wr_en}), 64'b10);
    step();
    check("t5_err_sticky", 64'({err_unexp, wr_en, busy}), 64'b100);

    // 3: zero length -> done two cycles after start, no traffic; clears err_unexp
    cfg_len = 9'd0;
    pulse_start();
    check("t3_err_cleared", 64'(err_unexp), 64'(0));
    trace(1, 6);
    check("t3_no_traffic", 64'({tr_rd, tr_me, tr_wr}), 64'(0));
    check("t3_done", 64'(tr_dn), 64'h4);
    check("t3_busy", 64'(tr_bz), 64'h6);

    // 4: abort in the cycle of the 4th read -> 3 ops in flight flushed
    cfg_len = 9'd8; cfg_rd_base = 8'h20; cfg_wr_base = 8'h40;
    pulse_start();
    trace(1, 3);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_issue_dropped", 64'({rd_en, mau_enable}), 64'(0));
    trace(5, 10);
    check("t4_no_wr_done", 64'({tr_wr, tr_dn, tr_me}), 64'(0));
    check("t4_busy", 64'(tr_bz), 64'h1E0);
    check("t4_no_unexp", 64'(err_unexp), 64'(0));

    // 2: N=256 with wrapping read and write addresses
    cfg_len = 9'h100; cfg_rd_base = 8'h80; cfg_wr_base = 8'hF0;
    pulse_start();
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
    for (int k = 1; k <= 320; k++) begin
      if (rd_en) begin
        if (rd_cnt == 0)   check("t2_rd_addr_first", 64'(rd_addr), 64'h80);
        if (rd_cnt == 128) check("t2_rd_addr_wrap", 64'(rd_addr), 64'h00);
        rd_cnt++;
      end
      if (wr_en) begin
        if (wr_cnt == 16) check("t2_wr_addr_wrap", 64'(wr_addr), 64'h00);
        wr_cnt++;
      end
      if (done) done_cnt++;
      step();
    end
    check("t2_counts", 64'({16'(rd_cnt), 16'(wr_cnt), 16'(done_cnt), 15'd0, busy}),
          64'({16'd256, 16'd256, 16'd1, 15'd0, 1'b0}));
    for (int i = 0; i < 256; i++) begin
      check("t2_result", 64'(res[8'(8'hF0 + i)]), 64'(exp_res(8'(8'h80 + i))));
    end

`ifdef POLY_SEQ_TIMEOUT_EN
    // 6: last result dropped -> watchdog exit after 64 silent DRAIN cycles
    cfg_len = 9'd4; cfg_rd_base = 8'h00; cfg_wr_base = 8'h60;
    pulse_start();
    repeat (4) step();
    suppress = 1'b1;
    step();
    suppress = 1'b0;
    done_cnt = 0; drop_cyc = 0;
    for (int k = 6; k < 120; k++) begin
      if (done) done_cnt++;
      if (!busy && drop_cyc == 0) drop_cyc = k;
      step();
    end
    check("t6_idle_cycle", 64'(drop_cyc), 64'd72);
    check("t6_err_timeout", 64'({err_timeout, 8'(done_cnt)}), 64'({1'b1, 8'd0}));
    cfg_len = 9'd0;
    pulse_start();
    check("t6_err_cleared", 64'(err_timeout), 64'(0));
    repeat (3) step();
`endif

    // Reset mid-job returns everything to idle/zero
    cfg_len = 9'd8; cfg_rd_base = 8'h00; cfg_alu_mode = 4'h9;
    pulse_start();
    repeat (2) step();
    rst = 1'b1;
    step();
    check("rst_midjob", 64'({busy, rd_en, mau_enable, wr_en, mau_alu_mode}), 64'(0));
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
